// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared widths, state/op encodings and constants for multdiv_unit
package multdiv_pkg;
    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;
    localparam logic [31:0] INT_MIN = 32'h80000000;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic {OP_MULT = 1'b0, OP_DIV = 1'b1} op_t;
endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one restoring-division iteration on magnitudes
module restoring_div_step (
    input  logic [32:0] i_rem,
    input  logic [31:0] i_dvs,
    input  logic        i_bit,
    output logic [32:0] o_rem,
    output logic        o_q
);
    logic [33:0] w_sh;
    logic [32:0] w_diff;
    // shift in the next dividend bit and subtract the divisor when it fits
    always_comb begin
        w_sh   = {i_rem, i_bit};
        w_diff = w_sh[32:0] - {1'b0, i_dvs};
        o_q    = w_sh >= {2'b00, i_dvs};
        o_rem  = o_q ? w_diff : w_sh[32:0];
    end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative 32-cycle signed Booth multiply / restoring divide
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    op_t         r_op;
    logic [32:0] r_hi;
    logic [31:0] r_lo, r_m;
    logic        r_q1, r_neg, r_dz, r_ovf;
    logic [31:0] r_result;
    logic        r_exc, r_rdy, r_busy;
    logic        w_start, w_mult;
    logic [31:0] w_abs_a, w_abs_b;
    logic [1:0]  w_booth;
    logic [32:0] w_badd, w_drem, w_hi_n, w_prod_top;
    logic [31:0] w_lo_n, w_quo, w_res;
    logic        w_dq, w_exc;

    restoring_div_step u_step (
        .i_rem(r_hi),
        .i_dvs(r_m),
        .i_bit(r_lo[31]),
        .o_rem(w_drem),
        .o_q  (w_dq)
    );

    // next state: any start (re)enters RUN; counter wrap at 31 finishes the run
    always_comb begin
        w_start = ctrl_MULT | ctrl_DIV;
        w_next  = r_state;
        w_next  = w_start ? RUN : (r_state == RUN) ? ((r_cnt == 5'd31) ? DONE : RUN) : IDLE;
    end

    // one Booth or restoring-divide iteration and the final result formatting
    always_comb begin
        w_mult     = ctrl_MULT;
        w_abs_a    = data_operandA[31] ? -data_operandA : data_operandA;
        w_abs_b    = data_operandB[31] ? -data_operandB : data_operandB;
        w_booth    = {r_lo[0], r_q1};
        w_badd     = (w_booth == 2'b01) ? r_hi + {r_m[31], r_m} :
                     (w_booth == 2'b10) ? r_hi - {r_m[31], r_m} : r_hi;
        w_hi_n     = (r_op == OP_MULT) ? {w_badd[32], w_badd[32:1]} : w_drem;
        w_lo_n     = (r_op == OP_MULT) ? {w_badd[0], r_lo[31:1]} : {r_lo[30:0], w_dq};
        w_prod_top = {w_hi_n[31:0], w_lo_n[31]};
        w_quo      = r_neg ? -w_lo_n : w_lo_n;
        w_res      = (r_op == OP_MULT) ? w_lo_n : r_dz ? 32'd0 : w_quo;
        w_exc      = (r_op == OP_MULT) ? ~((&w_prod_top) | ~(|w_prod_top)) : (r_dz | r_ovf);
    end

    // state, iteration counter and registered handshake outputs
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_start ? 5'd0 : (r_state == RUN) ? r_cnt + 5'd1 : r_cnt;
            r_rdy   <= w_next == DONE;
            r_busy  <= w_next != IDLE;
        end
    end

    // operand capture on start, iteration update while running
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_op  <= OP_MULT;
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_q1  <= 1'b0;
            r_neg <= 1'b0;
            r_dz  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_op  <= w_mult ? OP_MULT : OP_DIV;
            r_hi  <= '0;
            r_q1  <= 1'b0;
            r_lo  <= w_mult ? data_operandA : w_abs_a;
            r_m   <= w_mult ? data_operandB : w_abs_b;
            r_neg <= ~w_mult & (data_operandA[31] ^ data_operandB[31]);
            r_dz  <= ~w_mult & (data_operandB == 32'd0);
            r_ovf <= ~w_mult & (data_operandA == INT_MIN) & (data_operandB == 32'hFFFFFFFF);
        end else if (r_state == RUN) begin
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
            r_q1 <= r_lo[0];
        end
    end

    // result and exception only change when entering DONE
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_next == DONE) begin
            r_result <= w_res;
            r_exc    <= w_exc;
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed vector bench for multdiv_unit
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;
    vec_t v[13];

    multdiv_unit dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (data_resultRDY) break;
        end
    endtask

    initial begin
        int n, pulses, first;
        v[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0};
        v[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        v[2]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};
        v[3]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
        v[4]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h00000000, 1'b1};
        v[5]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        v[6]  = '{1'b0, 1'b1, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
        v[7]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        v[8]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        v[9]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        v[10] = '{1'b1, 1'b1, 32'd6,        32'd2,        32'd12,       1'b0};
        v[11] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0};
        v[12] = '{1'b1, 1'b0, 32'hFFFF0000, 32'h00008000, 32'h80000000, 1'b0};

        repeat (3) @(posedge clock);
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        ctrl_reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 13; i++) begin
            start(v[i].m, v[i].d, v[i].a, v[i].b);
            chk($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
            wait_rdy(n);
            chk($sformatf("v%0d latency", i), n, 32'd32);
            chk($sformatf("v%0d result", i), data_result, v[i].res);
            chk($sformatf("v%0d exception", i), {31'd0, data_exception}, {31'd0, v[i].exc});
            @(posedge clock);
            #1;
            chk($sformatf("v%0d busy after", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d rdy after", i), {31'd0, data_resultRDY}, 32'd0);
        end

        start(1'b1, 1'b0, 32'd2, 32'd3);
        wait_rdy(n);
        chk("b2b first result", data_result, 32'd6);
        start(1'b1, 1'b0, 32'd5, 32'd5);
        chk("b2b busy held", {31'd0, busy}, 32'd1);
        chk("b2b rdy cleared", {31'd0, data_resultRDY}, 32'd0);
        wait_rdy(n);
        chk("b2b latency", n, 32'd32);
        chk("b2b result", data_result, 32'd25);

        @(posedge clock);
        #1;
        start(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        #1;
        start(1'b0, 1'b1, 32'd9, 32'd3);
        pulses = 0;
        first = 0;
        for (int i = 2; i <= 41; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                pulses++;
                if (first == 0) first = i - 1;
            end
        end
        chk("restart pulses", pulses, 32'd1);
        chk("restart latency", first, 32'd32);
        chk("restart result", data_result, 32'd3);

        start(1'b0, 1'b1, 32'd100, 32'd10);
        repeat (14) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        @(posedge clock);
        #1;
        ctrl_reset = 1'b0;
        chk("midrun reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midrun reset busy", {31'd0, busy}, 32'd0);
        chk("midrun reset result", data_result, 32'd0);
        chk("midrun reset exception", {31'd0, data_exception}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("post reset pulses", pulses, 32'd0);
        chk("post reset result", data_result, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
